// File: rtl/wide_add_seq_if.sv
// Start/busy/done handshake and operand/result bus for the wide adder sequencer.
interface wide_add_seq_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned WORDS = 4
);
  logic                 start;
  logic [W*WORDS-1:0]   a;
  logic [W*WORDS-1:0]   b;
  logic                 cin;
  logic                 sub;
  logic                 busy;
  logic                 done;
  logic [W*WORDS-1:0]   sum;
  logic                 cout;
  logic                 ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one W-bit slice reused over WORDS cycles, LS word first,
// with the slice carry chained through a 1-bit register.
module wide_add_seq #(
  parameter int unsigned W     = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  wide_add_seq_if.slave bus
);

  localparam int unsigned N    = W * WORDS;
  localparam int unsigned IdxW = $clog2(WORDS);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [W:0]      slice;

  // Operands shift right each ADD cycle so the slice always sees the low word;
  // the sum shifts in from the top and lands fully aligned after WORDS cycles.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    slice   = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          idx_d   = '0;
          state_d = StAdd;
        end else begin
          state_d = StIdle;
        end
      end
      StAdd: begin
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        sum_d   = {slice[W-1:0], sum_q[N-1:W]};
        carry_d = slice[W];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IdxW'(WORDS - 1)) begin
          state_d = StDone;
          cout_d  = slice[W];
          // Carry into the MSB is recovered as s_msb ^ a_msb ^ b_msb.
          ovf_d   = slice[W] ^ slice[W-1] ^ a_q[W-1] ^ b_q[W-1];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == StAdd);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: behavioural 64-bit model checked every cycle plus
// directed vectors with hand-computed results.
module tb_wide_add_seq;
  localparam int unsigned W     = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = W * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  wide_add_seq_if #(.W(W), .WORDS(WORDS)) bus ();

  wide_add_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since accept (0 idle, 1..WORDS busy, WORDS+1 done) and
  // result computed directly as a 65-bit sum.
  int           m_cnt  = 0;
  logic [N-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [N-1:0] p_sum;
  logic         p_cout, p_ovf;

  always @(posedge clk or posedge rst) begin
    logic [N:0]   full;
    logic [N-1:0] bb;
    if (rst) begin
      m_cnt = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if ((m_cnt == 0 || m_cnt == WORDS + 1) && bus.start) begin
      bb     = bus.sub ? ~bus.b : bus.b;
      full   = {1'b0, bus.a} + {1'b0, bb} + {{N{1'b0}}, (bus.sub | bus.cin)};
      p_sum  = full[N-1:0];
      p_cout = full[N];
      p_ovf  = (bus.a[N-1] == bb[N-1]) && (full[N-1] != bus.a[N-1]);
      m_cnt  = 1;
    end else if (m_cnt >= 1 && m_cnt <= WORDS) begin
      m_cnt++;
      if (m_cnt == WORDS + 1) begin
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else begin
      m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    logic m_busy;
    m_busy = (m_cnt >= 1 && m_cnt <= WORDS);
    check("busy", N'(bus.busy), N'(m_busy));
    check("done", N'(bus.done), N'(m_cnt == WORDS + 1));
    if (!m_busy) begin
      check("sum", bus.sum, m_sum);
      check("cout", N'(bus.cout), N'(m_cout));
      check("ovf", N'(bus.ovf), N'(m_ovf));
    end
  end

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                       input logic sub, input logic start);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = start;
  endtask

  task automatic check_res(input string name, input logic [N-1:0] s, input logic c,
                           input logic v);
    check({name, "_sum"}, bus.sum, s);
    check({name, "_cout"}, N'(bus.cout), N'(c));
    check({name, "_ovf"}, N'(bus.ovf), N'(v));
    check({name, "_model"}, m_sum, s);
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub, input logic [N-1:0] s,
                        input logic c, input logic v);
    @(posedge clk); #1;
    drive(a, b, cin, sub, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(name);
    check_res(name, s, c, v);
  endtask

  initial begin
    int dones;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", N'(bus.busy), '0);
    check("reset_sum", bus.sum, '0);

    // Reset held 3 cycles in IDLE
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_rst_out", {bus.sum[N-1:4], bus.busy, bus.done, bus.cout, bus.ovf}, '0);
    end
    @(posedge clk); #1 rst = 1'b0;

    run_op("carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub5m7", 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub7m5", 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);
    run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
           64'h2222_2222_2222_2212, 1'b0, 1'b0);

    // start pulsed 2 cycles into an operation is ignored
    @(posedge clk); #1 drive(64'h100, 64'h200, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 drive(64'hDEAD, 64'hBEEF, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("ignored");
    check_res("ignored", 64'h300, 1'b0, 1'b0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("ignored_extra_done", N'(dones), '0);

    // start held through DONE: back-to-back accept
    @(posedge clk); #1 drive(64'h1, 64'h2, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 drive(64'h10, 64'h20, 1'b0, 1'b1, 1'b1);
    wait_done("b2b_first");
    check_res("b2b_first", 64'h3, 1'b0, 1'b0);
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble", N'(bus.busy), N'(1));
    wait_done("b2b_second");
    check_res("b2b_second", 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);

    // Reset 2 cycles after accept aborts
    @(posedge clk); #1 drive(64'hFFFF, 64'hFFFF, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("abort_busy", N'(bus.busy), '0);
    check("abort_out", {bus.sum[N-1:4], bus.done, bus.cout, bus.ovf, 1'b0}, '0);
    @(posedge clk); #1 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", N'(dones), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle wide-operand adder sequencer: reuses one W-bit adder slice across WORDS consecutive cycles to add two (W*WORDS)-bit operands, least-significant word first, chaining the slice carry through a carry register.
- Used wherever a wide add/subtract is needed but only one 16-bit adder slice is affordable.
- Start/busy/done handshake toward the issuing controller.

Parameters:
- W, 16, width of the shared adder slice in bits.
- WORDS, 4, number of slices per operation; operand width = W*WORDS (64 by default). Legal range 2..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a new operation; sampled on the rising edge of clk.
- a  input  W*WORDS  operand A; captured when start is accepted.
- b  input  W*WORDS  operand B; captured when start is accepted.
- cin  input  1  carry-in for word 0; captured on accept; ignored when sub=1.
- sub  input  1  1 = subtract (A + ~B + 1); captured on accept.
- busy  output  1  high while the operation is in the ADD state.
- done  output  1  one-cycle pulse; the result is valid from this cycle.
- sum  output  W*WORDS  result; held until the next accepted start.
- cout  output  1  carry out of the MSB. For sub=1, cout=1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: asynchronous, active-high. On reset, state=IDLE and busy, done, sum, cout, ovf, the word index, the carry register and the operand registers are all 0.
- States:
  - IDLE: start=1 → latch a, b (b inverted if sub=1) and carry=(sub ? 1 : cin). Go to ADD with idx=0.
  - ADD: each edge computes {c, s} = A[idx] + B[idx] + carry, W+1 bits wide. Writes s into sum word idx, updates carry, increments idx. On the edge where idx=WORDS-1, go to DONE and register cout and ovf from the top slice.
  - DONE: done=1 for this cycle only. Next edge: start=1 → accept exactly as in IDLE (back-to-back, no idle bubble); otherwise go to IDLE.
- Latency: start accepted at edge E0. busy is high from after E0 through the cycle ending at edge E_WORDS. done is high in the cycle after E_WORDS, i.e. WORDS+1 edges after acceptance (5 by default).
- Throughput: one operation per WORDS+1 cycles with back-to-back starts.
- start while in ADD: ignored. No queuing, no error flag.
- Operand inputs are don't-care except on the accept edge.
- sum update rule:
  - sum words update progressively during ADD; intermediate values are not guaranteed.
  - On accept, sum is not cleared.
  - cout, ovf and all sum words are stable from done until the next accept.
- Arithmetic: modulo 2^(W*WORDS). The carry register is 1 bit. ovf uses the carry into bit W-1 of the top slice, which equals the slice MSB sum bit XOR A_msb XOR B_msb (with B already inverted for sub).
- Reset mid-operation: immediate abort. State=IDLE, done is never asserted for the aborted operation, all outputs are 0.
- No combinational path from any input to any output. All outputs are registered or decoded directly from state.

Test Plan:
- Reset → busy=0, done=0, sum=0, cout=0, ovf=0. Assert rst during IDLE and hold 3 cycles; outputs stay 0.
- a=0x0000_0000_0000_FFFF, b=0x1, cin=0, sub=0, start for 1 cycle → busy high 4 cycles, done pulses 1 cycle at edge 5, sum=0x0000_0000_0001_0000, cout=0, ovf=0.
- a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0.
- Signed overflow, a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract, a=5, b=7, sub=1, cin=1 (ignored) → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Repeat with a=7, b=5 → sum=2, cout=1.
- Handshake and abort:
  - Pulse start again 2 cycles into an operation → ignored; exactly one done, result from the first operands.
  - Hold start high through DONE → second operation accepted with no idle cycle.
  - Assert rst 2 cycles after accept → busy drops at once, no done, all outputs 0.
